// File: rtl/pd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pd_pkg
//  Description : Shared encodings for the phase detector lock tracker:
//                lock FSM state codes and lead/lag event-type codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pd_pkg;

    // Lock tracker state encoding
    localparam int unsigned       c_ST_W      = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_TRACK  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_LOCKED = 2'd2;

    // Event-type encoding stored in the last-event register
    localparam logic c_EV_LEAD = 1'b0;
    localparam logic c_EV_LAG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pd_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pd_lock_fsm
//  Description : Lock tracker. Counts consecutive alternating lead/lag events
//                and declares lock once LOCK_CNT alternations have been seen.
//                A repeated event type breaks the run; i_clear parks in IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module pd_lock_fsm
    import pd_pkg::*;
#(
    parameter int LOCK_CNT = 8
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_lag,
    input  logic i_lead,
    output logic o_lock
);

    localparam int                 c_ALT_W = $clog2(LOCK_CNT + 1);
    localparam logic [c_ALT_W-1:0] c_LOCK  = c_ALT_W'(LOCK_CNT);
    localparam logic [c_ALT_W-1:0] c_ONE   = c_ALT_W'(1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [c_ALT_W-1:0] r_alt;
    logic [c_ALT_W-1:0] w_alt_nxt;
    logic [c_ALT_W-1:0] w_alt_inc;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_lock;
    logic               w_lock_nxt;
    logic               w_ev;
    logic               w_ev_type;

    // Event strobes are mutually exclusive; a lag strobe wins the type select
    assign w_ev      = i_lag | i_lead;
    assign w_ev_type = i_lag ? c_EV_LAG : c_EV_LEAD;
    // Alternation count saturates at the lock threshold
    assign w_alt_inc = (r_alt >= c_LOCK) ? c_LOCK : (r_alt + c_ONE);

    // State, alternation count, last event and lock flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_alt   <= '0;
            r_last  <= c_EV_LEAD;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alt   <= w_alt_nxt;
            r_last  <= w_last_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // Next-state logic: run tracking on each non-tie event
    always_comb begin
        w_state_nxt = r_state;
        w_alt_nxt   = r_alt;
        w_last_nxt  = r_last;
        if (i_clear) begin
            w_state_nxt = c_ST_IDLE;
            w_alt_nxt   = '0;
        end else if (w_ev) begin
            w_last_nxt = w_ev_type;
            case (r_state)
                c_ST_IDLE: begin
                    // LAST is stale here; the first event just opens a run
                    w_state_nxt = c_ST_TRACK;
                    w_alt_nxt   = '0;
                end
                c_ST_TRACK: begin
                    if (w_ev_type != r_last) begin
                        w_alt_nxt = w_alt_inc;
                        if (w_alt_inc == c_LOCK) begin
                            w_state_nxt = c_ST_LOCKED;
                        end
                    end else begin
                        w_alt_nxt = '0;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_ev_type == r_last) begin
                        w_state_nxt = c_ST_TRACK;
                        w_alt_nxt   = '0;
                    end else begin
                        w_alt_nxt = w_alt_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_alt_nxt   = '0;
                end
            endcase
        end
    end

    // Output logic: lock flag follows the upcoming state, then is registered
    always_comb begin
        w_lock_nxt = (w_state_nxt == c_ST_LOCKED);
    end

    assign o_lock = r_lock;

endmodule
`default_nettype wire

// File: rtl/phase_detect_lock.sv
`default_nettype none
// ============================================================================
//  Module      : phase_detect_lock
//  Description : Divider-count phase detector. Decodes lead/lag events from
//                the M and N divider counters, produces registered COMP and
//                single-cycle UP/DN pulses, and tracks lock via pd_lock_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_detect_lock
    import pd_pkg::*;
#(
    parameter int MW       = 2,
    parameter int NW       = 4,
    parameter int LOCK_CNT = 8
)
(
    input  logic          clk_out,
    input  logic          Reset_PD_n,
    input  logic          en,
    input  logic [MW-1:0] M_counter,
    input  logic [NW-1:0] N_counter,
    input  logic [MW-1:0] M,
    input  logic [NW-1:0] N,
    output logic          COMP,
    output logic          UP,
    output logic          DN,
    output logic          LOCK,
    output logic          cfg_err
);

    localparam logic [MW-1:0] c_M_ONE = MW'(1);
    localparam logic [NW-1:0] c_N_ONE = NW'(1);

    logic w_cfg_cond;
    logic w_lag_raw;
    logic w_lead_raw;
    logic w_lag;
    logic w_lead;
    logic w_clear;
    logic r_comp;
    logic r_up;
    logic r_dn;
    logic r_cfg_err;

    // A zero divide ratio makes the counters meaningless, so events are masked
    assign w_cfg_cond = (M == '0) | (N == '0);
    assign w_lag_raw  = en & ~w_cfg_cond & (M_counter == M) & (N_counter == c_N_ONE);
    assign w_lead_raw = en & ~w_cfg_cond & (M_counter == c_M_ONE) & (N_counter == N);
    // Simultaneous lead and lag is a tie and carries no phase information
    assign w_lag      = w_lag_raw & ~w_lead_raw;
    assign w_lead     = w_lead_raw & ~w_lag_raw;
    assign w_clear    = ~en | w_cfg_cond;

    // Comparison result, pulse outputs and configuration flag
    always_ff @(posedge clk_out) begin
        if (!Reset_PD_n) begin
            r_comp    <= 1'b0;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_cond;
            r_up      <= w_lag;
            r_dn      <= w_lead;
            if (w_lag) begin
                r_comp <= 1'b1;
            end else if (w_lead) begin
                r_comp <= 1'b0;
            end
        end
    end

    pd_lock_fsm #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_fsm (
        .clk     (clk_out),
        .rst_n   (Reset_PD_n),
        .i_clear (w_clear),
        .i_lag   (w_lag),
        .i_lead  (w_lead),
        .o_lock  (LOCK)
    );

    assign COMP    = r_comp;
    assign UP      = r_up;
    assign DN      = r_dn;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_phase_detect_lock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_detect_lock
//  Description : Scoreboard bench for phase_detect_lock. The driver predicts
//                each cycle's outputs from a run-length model of alternating
//                events; a separate monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_detect_lock;

    localparam int MW       = 2;
    localparam int NW       = 4;
    localparam int LOCK_CNT = 8;

    typedef struct packed {
        logic        comp;
        logic        up;
        logic        dn;
        logic        lock;
        logic        cfg;
        logic [15:0] seq;
    } exp_t;

    logic          clk_out = 1'b0;
    logic          Reset_PD_n = 1'b0;
    logic          en = 1'b0;
    logic [MW-1:0] M_counter = '0;
    logic [NW-1:0] N_counter = '0;
    logic [MW-1:0] M = '0;
    logic [NW-1:0] N = '0;
    logic          COMP;
    logic          UP;
    logic          DN;
    logic          LOCK;
    logic          cfg_err;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq     = 0;

    // Reference model state: COMP value and length of current alternating run
    logic mdl_comp = 1'b0;
    logic mdl_last = 1'b0;
    int   mdl_run  = 0;
    logic gen_prev = 1'b0;

    phase_detect_lock #(
        .MW       (MW),
        .NW       (NW),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk_out    (clk_out),
        .Reset_PD_n (Reset_PD_n),
        .en         (en),
        .M_counter  (M_counter),
        .N_counter  (N_counter),
        .M          (M),
        .N          (N),
        .COMP       (COMP),
        .UP         (UP),
        .DN         (DN),
        .LOCK       (LOCK),
        .cfg_err    (cfg_err)
    );

    always #5 clk_out = ~clk_out;

    // Drive one cycle of inputs and push the outputs expected after the edge.
    // Lock model: a run is a maximal chain of alternating events; it holds
    // lock once it contains more than LOCK_CNT events (LOCK_CNT alternations).
    task automatic drive(input logic rst_v, input logic en_v, input int mc,
                         input int nc, input int m, input int n);
        exp_t e;
        logic cfgc, lag, lead, up, dn;
        @(negedge clk_out);
        Reset_PD_n = rst_v;
        en         = en_v;
        M_counter  = MW'(mc);
        N_counter  = NW'(nc);
        M          = MW'(m);
        N          = NW'(n);
        cfgc = (M == 0) || (N == 0);
        lag  = en && !cfgc && (M_counter == M) && (N_counter == 1);
        lead = en && !cfgc && (M_counter == 1) && (N_counter == N);
        up   = lag && !lead;
        dn   = lead && !lag;
        if (!Reset_PD_n) begin
            mdl_comp = 1'b0;
            mdl_run  = 0;
            e.up  = 1'b0;
            e.dn  = 1'b0;
            e.cfg = 1'b0;
        end else begin
            if (up) mdl_comp = 1'b1;
            else if (dn) mdl_comp = 1'b0;
            if (!en || cfgc) begin
                mdl_run = 0;
            end else if (up || dn) begin
                if (mdl_run > 0 && up != mdl_last) mdl_run++;
                else mdl_run = 1;
                mdl_last = up;
            end
            e.up  = up;
            e.dn  = dn;
            e.cfg = cfgc;
        end
        e.comp = mdl_comp;
        e.lock = (mdl_run > LOCK_CNT);
        e.seq  = 16'(seq);
        seq++;
        sb.push_back(e);
    endtask

    task automatic lag_ev(input int m, input int n);
        drive(1'b1, 1'b1, m, 1, m, n);
    endtask

    task automatic lead_ev(input int m, input int n);
        drive(1'b1, 1'b1, 1, n, m, n);
    endtask

    task automatic quiet(input int m, input int n);
        drive(1'b1, 1'b1, 0, 0, m, n);
    endtask

    // Clear any run with en low, then issue 9 alternating events from a lead
    task automatic lock_up(input int m, input int n);
        drive(1'b1, 1'b0, 0, 0, m, n);
        for (int k = 0; k < LOCK_CNT + 1; k++) begin
            if (k % 2 == 0) lead_ev(m, n);
            else lag_ev(m, n);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp,
                             input int s);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s seq=%0d actual=%0b required=%0b", name, s, act, exp);
        end
    endtask

    // Monitor: every active edge the DUT presents a result; compare it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_out);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_bit("comp", COMP, e.comp, int'(e.seq));
                check_bit("up", UP, e.up, int'(e.seq));
                check_bit("dn", DN, e.dn, int'(e.seq));
                check_bit("lock", LOCK, e.lock, int'(e.seq));
                check_bit("cfg_err", cfg_err, e.cfg, int'(e.seq));
                check_bit("up_dn_excl", UP & DN, 1'b0, int'(e.seq));
            end
        end
    end

    // Stimulus: directed scenarios followed by biased random traffic
    initial begin
        int m, n, r, mc, nc;
        logic rst_v, en_v;

        repeat (3) drive(1'b0, 1'b0, 0, 0, 0, 0);
        quiet(2, 5);

        // Lag event -> COMP=1 and a single UP pulse
        lag_ev(2, 5);
        quiet(2, 5);
        quiet(2, 5);

        // Lock after 8 alternations, hold, then lose it on a repeated lag
        lock_up(2, 5);
        quiet(2, 5);
        quiet(2, 5);
        lag_ev(2, 5);
        lag_ev(2, 5);
        quiet(2, 5);

        // Reset while locked overrides everything
        lock_up(2, 5);
        drive(1'b0, 1'b1, 2, 1, 2, 5);
        quiet(2, 5);

        // Tie: COMP held at 1, no pulses
        lag_ev(2, 5);
        drive(1'b1, 1'b1, 1, 1, 1, 1);
        drive(1'b1, 1'b1, 1, 1, 1, 1);
        quiet(1, 1);

        // Zero N while locked: flag raised, events ignored, lock dropped
        lock_up(2, 5);
        drive(1'b1, 1'b1, 1, 0, 2, 0);
        drive(1'b1, 1'b1, 2, 1, 2, 0);
        quiet(2, 5);

        // Enable dropped while locked: lock clears, COMP held
        lock_up(3, 7);
        drive(1'b1, 1'b0, 3, 1, 3, 7);
        drive(1'b1, 1'b0, 1, 7, 3, 7);
        lead_ev(3, 7);

        // Random traffic biased toward alternation so that locks occur
        m = 2;
        n = 5;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                m = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
                n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            end
            rst_v = ($urandom_range(0, 199) != 0);
            en_v  = ($urandom_range(0, 39) != 0);
            r = int'($urandom_range(0, 19));
            if (r < 17) gen_prev = ~gen_prev;
            if (r < 18) begin
                mc = gen_prev ? m : 1;
                nc = gen_prev ? 1 : n;
            end else begin
                mc = int'($urandom_range(0, 3));
                nc = int'($urandom_range(0, 15));
            end
            drive(rst_v, en_v, mc, nc, m, n);
        end

        repeat (3) @(negedge clk_out);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
